// File: rtl/arm_pkg.sv
// Shared types and constants for the reduced ARM core IRQ entry path.
package arm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BOUND,
    S_WR_LR,
    S_WR_PSR,
    S_REDIRECT
  } irq_state_t;

  localparam int CPSR_I = 7;
  localparam int CPSR_F = 6;
  localparam int CPSR_T = 5;
  localparam int CPSR_MODE_HI = 4;

  localparam logic [4:0] CPSR_MODE_USR = 5'b10000;
  localparam logic [4:0] CPSR_MODE_IRQ = 5'b10010;
  localparam logic [4:0] CPSR_MODE_SVC = 5'b10011;

  localparam logic [3:0] LR_IDX = 4'd14;

endpackage

// File: rtl/arm_irq_sequencer_if.sv
// Write-back bundle driven by the IRQ sequencer onto RF, PSRs and PC load.
interface arm_irq_sequencer_if;

  logic        stall;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        rf_bank_irq;
  logic [31:0] rf_wdata;
  logic        spsr_we;
  logic [31:0] spsr_wdata;
  logic        cpsr_we;
  logic [31:0] cpsr_wdata;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        irq_ack;
  logic        busy;
  logic [15:0] irq_latency;

  modport master (
    output stall, rf_we, rf_waddr, rf_bank_irq, rf_wdata,
    output spsr_we, spsr_wdata, cpsr_we, cpsr_wdata,
    output pc_load, pc_target, irq_ack, busy, irq_latency
  );

  modport slave (
    input stall, rf_we, rf_waddr, rf_bank_irq, rf_wdata,
    input spsr_we, spsr_wdata, cpsr_we, cpsr_wdata,
    input pc_load, pc_target, irq_ack, busy, irq_latency
  );

endinterface

// File: rtl/arm_irq_sync.sv
// Multi-flop synchronizer for the asynchronous nIRQ line, resets deasserted.
module arm_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '1;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/arm_irq_sequencer.sv
// IRQ entry sequencer: LR_irq, SPSR/CPSR update, PC redirect to vector.
// Optional IRQ_LATENCY_CNT_EN adds an entry-latency counter.
module arm_irq_sequencer
  import arm_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0018,
  parameter int          SYNC_STAGES = 2,
  parameter logic [4:0]  MODE_IRQ    = CPSR_MODE_IRQ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nirq,
  input  logic        inst_boundary,
  input  logic [31:0] cur_pc,
  input  logic [31:0] cur_cpsr,
  arm_irq_sequencer_if.master bus
);

  irq_state_t  state, nxt;
  logic        irq_sync;
  logic        irq_req;
  logic        capture;
  logic [31:0] saved_pc;
  logic [31:0] saved_cpsr;

  arm_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nirq),
    .q     (irq_sync)
  );

  assign irq_req = ~irq_sync & ~cur_cpsr[CPSR_I];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      saved_pc   <= '0;
      saved_cpsr <= '0;
    end else begin
      state <= nxt;
      if (capture) begin
        saved_pc   <= cur_pc;
        saved_cpsr <= cur_cpsr;
      end
    end
  end

  always_comb begin
    nxt     = state;
    capture = 1'b0;
    unique case (state)
      S_IDLE, S_WAIT_BOUND: begin
        if (irq_req && inst_boundary) begin
          nxt     = S_WR_LR;
          capture = 1'b1;
        end else if (irq_req) begin
          nxt = S_WAIT_BOUND;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_WR_LR:    nxt = S_WR_PSR;
      S_WR_PSR:   nxt = S_REDIRECT;
      S_REDIRECT: nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // Outputs decode only registered state so no input reaches them.
  always_comb begin
    bus.stall       = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = 4'd0;
    bus.rf_bank_irq = 1'b0;
    bus.rf_wdata    = 32'd0;
    bus.spsr_we     = 1'b0;
    bus.spsr_wdata  = 32'd0;
    bus.cpsr_we     = 1'b0;
    bus.cpsr_wdata  = 32'd0;
    bus.pc_load     = 1'b0;
    bus.pc_target   = 32'd0;
    bus.irq_ack     = 1'b0;
    bus.busy        = (state != S_IDLE);
    unique case (state)
      S_WR_LR: begin
        bus.stall       = 1'b1;
        bus.rf_we       = 1'b1;
        bus.rf_waddr    = LR_IDX;
        bus.rf_bank_irq = 1'b1;
        bus.rf_wdata    = saved_pc + 32'd4;
      end
      S_WR_PSR: begin
        bus.stall      = 1'b1;
        bus.spsr_we    = 1'b1;
        bus.spsr_wdata = saved_cpsr;
        bus.cpsr_we    = 1'b1;
        bus.cpsr_wdata = {saved_cpsr[31:8], 1'b1,
                          saved_cpsr[CPSR_F], 1'b0, MODE_IRQ};
      end
      S_REDIRECT: begin
        bus.stall     = 1'b1;
        bus.pc_load   = 1'b1;
        bus.pc_target = VECTOR_ADDR;
        bus.irq_ack   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef IRQ_LATENCY_CNT_EN
  logic [15:0] lat_cnt;
  logic [15:0] lat_q;
  logic [15:0] lat_inc;

  assign lat_inc = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

  // Snapshot includes the REDIRECT cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
      lat_q   <= '0;
    end else begin
      if (state == S_IDLE && nxt != S_IDLE) lat_cnt <= '0;
      else if (state != S_IDLE)             lat_cnt <= lat_inc;
      if (state == S_REDIRECT)              lat_q   <= lat_inc;
    end
  end

  assign bus.irq_latency = lat_q;
`else
  assign bus.irq_latency = 16'h0;
`endif

endmodule

// File: tb/tb_arm_irq_sequencer.sv
// Directed self-checking bench for arm_irq_sequencer.
module tb_arm_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        nirq = 1'b1;
  logic        inst_boundary = 1'b0;
  logic [31:0] cur_pc = '0;
  logic [31:0] cur_cpsr = 32'h13;

  int asserts = 0;
  int fails = 0;
  int acc;

  arm_irq_sequencer_if bus ();

  arm_irq_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .nirq          (nirq),
    .inst_boundary (inst_boundary),
    .cur_pc        (cur_pc),
    .cur_cpsr      (cur_cpsr),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int any_act();
    return int'(bus.stall) + int'(bus.busy) + int'(bus.rf_we) +
           int'(bus.spsr_we) + int'(bus.cpsr_we) + int'(bus.pc_load) +
           int'(bus.irq_ack);
  endfunction

  initial begin
    #12;
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_pc_target", bus.pc_target, 32'd0);
    chk("rst_latency", {16'd0, bus.irq_latency}, 32'd0);

    // Basic entry with boundary always high
    cur_cpsr = 32'h13;
    cur_pc = 32'h100;
    inst_boundary = 1'b1;
    nirq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10 && !bus.stall; i++) step();
    chk("t1_stall_seen", {31'd0, bus.stall}, 32'd1);
    chk("t1_rf_we", {31'd0, bus.rf_we}, 32'd1);
    chk("t1_rf_waddr", {28'd0, bus.rf_waddr}, 32'd14);
    chk("t1_bank", {31'd0, bus.rf_bank_irq}, 32'd1);
    chk("t1_rf_wdata", bus.rf_wdata, 32'h104);
    chk("t1_lr_no_psr", {31'd0, bus.cpsr_we}, 32'd0);
    step();
    chk("t1_psr_stall", {31'd0, bus.stall}, 32'd1);
    chk("t1_spsr_we", {31'd0, bus.spsr_we}, 32'd1);
    chk("t1_spsr_wdata", bus.spsr_wdata, 32'h13);
    chk("t1_cpsr_we", {31'd0, bus.cpsr_we}, 32'd1);
    chk("t1_cpsr_wdata", bus.cpsr_wdata, 32'h92);
    chk("t1_psr_no_rf", {31'd0, bus.rf_we}, 32'd0);
    step();
    chk("t1_redir_stall", {31'd0, bus.stall}, 32'd1);
    chk("t1_pc_load", {31'd0, bus.pc_load}, 32'd1);
    chk("t1_pc_target", bus.pc_target, 32'h18);
    chk("t1_irq_ack", {31'd0, bus.irq_ack}, 32'd1);
    cur_cpsr = 32'h93;
    step();
    chk("t1_stall_done", {31'd0, bus.stall}, 32'd0);
    chk("t1_ack_once", {31'd0, bus.irq_ack}, 32'd0);
    chk("t1_idle", {31'd0, bus.busy}, 32'd0);
`ifdef IRQ_LATENCY_CNT_EN
    chk("t1_latency", {16'd0, bus.irq_latency}, 32'd3);
`else
    chk("t1_latency", {16'd0, bus.irq_latency}, 32'd0);
`endif

    // I bit masks a held request
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc += any_act();
    end
    chk("t2_masked_activity", acc, 32'd0);

    // Request without boundary, then released
    inst_boundary = 1'b0;
    cur_cpsr = 32'h13;
    step();
    chk("t3_wait_busy", {31'd0, bus.busy}, 32'd1);
    chk("t3_wait_nostall", {31'd0, bus.stall}, 32'd0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc += int'(bus.stall) + int'(bus.rf_we) + int'(bus.irq_ack);
    end
    chk("t3_wait_still_busy", {31'd0, bus.busy}, 32'd1);
    nirq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      acc += int'(bus.stall) + int'(bus.rf_we) + int'(bus.spsr_we) +
             int'(bus.pc_load) + int'(bus.irq_ack);
    end
    chk("t3_no_writes", acc, 32'd0);
    chk("t3_back_idle", {31'd0, bus.busy}, 32'd0);

    // Late boundary plus LR wrap
    cur_pc = 32'hFFFF_FFFC;
    nirq = 1'b0;
    for (int i = 0; i < 10 && !bus.busy; i++) step();
    chk("t4_busy_seen", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("t4_still_waiting", {31'd0, bus.stall}, 32'd0);
    inst_boundary = 1'b1;
    step();
    chk("t4_rf_we", {31'd0, bus.rf_we}, 32'd1);
    chk("t4_rf_wrap", bus.rf_wdata, 32'h0);
    step();
    step();
    chk("t4_irq_ack", {31'd0, bus.irq_ack}, 32'd1);
    cur_cpsr = 32'h93;
    step();
`ifdef IRQ_LATENCY_CNT_EN
    chk("t4_latency", {16'd0, bus.irq_latency}, 32'd8);
`else
    chk("t4_latency", {16'd0, bus.irq_latency}, 32'd0);
`endif

    // Reset in the middle of WR_PSR
    cur_cpsr = 32'h13;
    for (int i = 0; i < 10 && !bus.stall; i++) step();
    chk("t5_stall_seen", {31'd0, bus.stall}, 32'd1);
    step();
    chk("t5_in_psr", {31'd0, bus.cpsr_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("t5_rst_cpsr_we", {31'd0, bus.cpsr_we}, 32'd0);
    chk("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_rst_latency", {16'd0, bus.irq_latency}, 32'd0);
    cur_cpsr = 32'h93;
    @(negedge clk);
    reset = 1'b1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc += int'(bus.pc_load) + int'(bus.irq_ack);
    end
    chk("t5_no_pc_load", acc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/arm_irq_sequencer.md
Name: arm_irq_sequencer

Overview:
Multi-cycle IRQ-entry controller for the reduced ARM core. Synchronizes the external active-low nIRQ, honours the CPSR I mask, and waits for an instruction boundary. It then stalls the core and drives the register file and status registers through the exception-entry sequence (LR_irq, SPSR, CPSR, PC redirect to the IRQ vector). It sits beside the ControlUnit and muxes onto the RegisterFile write port and the PC load path while stall is high.

Parameters:
VECTOR_ADDR, 32'h0000_0018, PC target loaded on IRQ entry
SYNC_STAGES, 2, flip-flop depth of the nirq synchronizer (>=2)
MODE_IRQ, 5'b10010, CPSR[4:0] mode value written on entry

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
nirq  input  1  external interrupt request, asynchronous, active-low, level-sensitive
inst_boundary  input  1  current instruction retires this cycle
cur_pc  input  32  address of next instruction to execute, valid with inst_boundary
cur_cpsr  input  32  current CPSR (bit7 = I, bit6 = F, bit5 = T, [4:0] = mode)
stall  output  1  freeze fetch/execute and yield RF write port and PC load to this block
rf_we  output  1  register file write enable
rf_waddr  output  4  register file write index
rf_bank_irq  output  1  select IRQ-banked copy of rf_waddr
rf_wdata  output  32  register file write data
spsr_we  output  1  SPSR_irq write enable
spsr_wdata  output  32  SPSR_irq write data
cpsr_we  output  1  CPSR write enable
cpsr_wdata  output  32  CPSR write data
pc_load  output  1  load PC from pc_target
pc_target  output  32  new PC value
irq_ack  output  1  one-cycle pulse: IRQ entry completed
busy  output  1  state != IDLE
irq_latency  output  16  see Optional Feature

Behaviour:
- Reset (reset=0, async): state=IDLE; synchronizer chain all 1 (deasserted); saved_pc/saved_cpsr=0; every output 0; pc_target=0. Reset mid-sequence aborts immediately and issues no further writes.
- irq_sync = nirq after SYNC_STAGES flops. irq_req = ~irq_sync & ~cur_cpsr[7].
- States: IDLE, WAIT_BOUND, WR_LR, WR_PSR, REDIRECT. Moore outputs are decoded from the state register; no combinational input-to-output path.
- IDLE:
  - irq_req & inst_boundary -> WR_LR; capture saved_pc=cur_pc, saved_cpsr=cur_cpsr.
  - irq_req & ~inst_boundary -> WAIT_BOUND.
  - Otherwise stay.
- WAIT_BOUND:
  - ~irq_req (nirq released or I set) -> IDLE. No latching; level semantics.
  - irq_req & inst_boundary -> WR_LR with capture as above.
  - Otherwise stay.
- WR_LR: stall=1, rf_we=1, rf_waddr=4'd14, rf_bank_irq=1, rf_wdata=saved_pc+32'd4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). Next state WR_PSR. The sequence is committed from here: nirq changes are ignored.
- WR_PSR: stall=1.
  - spsr_we=1, spsr_wdata=saved_cpsr.
  - cpsr_we=1, cpsr_wdata={saved_cpsr[31:8], 1'b1, saved_cpsr[6], 1'b0, MODE_IRQ}.
  - Next state REDIRECT.
- REDIRECT: stall=1, pc_load=1, pc_target=VECTOR_ADDR, irq_ack=1. Next state IDLE. The I bit is now set, so a held nirq does not re-enter.
- Entry latency: 3 stalled cycles after the boundary cycle. busy=1 in every non-IDLE state.

Optional Feature:
- Macro IRQ_LATENCY_CNT_EN.
- Defined:
  - 16-bit counter clears on the IDLE->non-IDLE transition and increments each cycle while busy.
  - Saturates at 16'hFFFF.
  - Value is frozen into irq_latency on the REDIRECT cycle and held until the next REDIRECT; reset value 0.
- Undefined: irq_latency tied to 16'h0; no counter logic.

Decomposition:
- Package arm_pkg holds:
  - state enum
  - CPSR bit positions (I=7, F=6, T=5, mode [4:0])
  - mode constants (USR/IRQ/SVC)
  - LR index 4'd14
- Sub-module arm_irq_sync: parameterized SYNC_STAGES synchronizer, reset value 1.

Test Plan:
- cur_cpsr=32'h0000_0013, nirq low, inst_boundary high constantly, cur_pc=32'h100 -> WR_LR writes r14_irq=32'h104; WR_PSR spsr=32'h13, cpsr=32'h92; REDIRECT pc_load with pc_target=32'h18; irq_ack once; stall exactly 3 cycles.
- cur_cpsr I=1 (32'h93), nirq low for 20 cycles -> no state change, busy=0, all write enables 0.
- nirq low, inst_boundary held 0 for 5 cycles, then nirq high -> WAIT_BOUND then back to IDLE; no writes, no irq_ack.
- cur_pc=32'hFFFF_FFFC at boundary -> rf_wdata=32'h0000_0000.
- reset pulsed low during WR_PSR -> all outputs 0 immediately; state IDLE; no pc_load follows.
- IRQ_LATENCY_CNT_EN defined, boundary arrives 4 cycles after irq_req -> irq_latency=16'd8 after irq_ack (5 WAIT_BOUND cycles + 3 stalled cycles).
